// File: rtl/fp8_mul_host_driver_if.sv
// Bus bundle between system logic, the fp8 multiplier host driver and the
// multiplier pins.
//   in_valid/in_ready/op_a/op_b : operand pair handshake (system -> driver)
//   res_valid/res_ready/res_data: product handshake (driver -> system)
//   busy                        : driver has a transaction in flight
//   dut_io_in                   : driver -> device pins {data[3:0], ctrl[2:0], pclk}
//   dut_io_out                  : device -> driver product pins
// master: the environment (system logic plus device); slave: the driver.
interface fp8_mul_host_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;
  logic [7:0] dut_io_in;
  logic [7:0] dut_io_out;

  modport master (
    output in_valid, op_a, op_b, res_ready, dut_io_out,
    input  in_ready, res_valid, res_data, busy, dut_io_in
  );

  modport slave (
    input  in_valid, op_a, op_b, res_ready, dut_io_out,
    output in_ready, res_valid, res_data, busy, dut_io_in
  );
endinterface

// File: rtl/fp8_mul_host_driver.sv
// Host-side driver for the fp8 multiplier nibble-load pin interface.
// Takes an operand pair, writes it to the device as four nibble stores with a
// generated pin clock, lets the combinational product settle, samples it and
// hands it back over a valid/ready handshake.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of fp8_mul_host_driver_if (handshakes, busy, device pins)
// Parameters:
//   DIV    : system cycles per pin-clock half period (>=1)
//   SETTLE : cycles the pins sit idle-low after the last write before sampling (>=1)
module fp8_mul_host_driver #(
  parameter int DIV    = 2,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fp8_mul_host_driver_if.slave bus
);

  localparam int CNT_MAX = (DIV > SETTLE) ? DIV : SETTLE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DIV_LAST    = CW'(DIV - 1);
  // Pins are registered, so they reach the idle value one cycle after WAIT
  // is entered; counting to SETTLE (not SETTLE-1) gives the device a full
  // SETTLE cycles of idle pins before the product is sampled.
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE);

  localparam logic [7:0] PIN_IDLE = 8'h02;

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    nib_q, nib_d;
  logic [7:0]    a_q, b_q;
  logic [7:0]    res_q;
  logic [7:0]    pin_q, pin_d;
  logic          accept;
  logic          sample;
  logic [3:0]    nib_data;
  logic [2:0]    nib_ctrl;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    accept  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = LOW;
          cnt_d   = '0;
          nib_d   = 2'd0;
        end
      end
      LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (nib_q == 2'd3) begin
            state_d = WAIT;
          end else begin
            nib_d   = nib_q + 2'd1;
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          sample  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Nibble n: bit0 of n picks the half, bit1 picks the operand.
  always_comb begin
    nib_data = 4'h0;
    case (nib_q)
      2'd0: nib_data = a_q[3:0];
      2'd1: nib_data = a_q[7:4];
      2'd2: nib_data = b_q[3:0];
      2'd3: nib_data = b_q[7:4];
      default: nib_data = 4'h0;
    endcase
    // ctrl = {half, operand, store_n}
    nib_ctrl = {nib_q[0], nib_q[1], 1'b0};
  end

  // Data/ctrl only change on entry to LOW, so every data change coincides
  // with pclk low and the device rising edge always sees stable data.
  always_comb begin
    pin_d = PIN_IDLE;
    case (state_q)
      LOW:     pin_d = {nib_data, nib_ctrl, 1'b0};
      HIGH:    pin_d = {nib_data, nib_ctrl, 1'b1};
      default: pin_d = PIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nib_q   <= 2'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      res_q   <= 8'h00;
      pin_q   <= PIN_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      pin_q   <= pin_d;
      if (accept) begin
        a_q <= bus.op_a;
        b_q <= bus.op_b;
      end
      if (sample) res_q <= bus.dut_io_out;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;
  assign bus.dut_io_in = pin_q;

endmodule
